// File: rtl/jacob_to_affine_ctrl.sv
// Jacobian-to-affine conversion sequencer: one shared inverter and one shared
// multiplier run the schedule Z^-1, zi*zi, X*z2, z2*zi, Y*z3i.
module jacob_to_affine_ctrl #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] y3,
  input  logic [W-1:0] z3,
  input  logic [W-1:0] p,
  output logic         busy,
  output logic         done,
  output logic         inf,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         inv_start,
  output logic [W-1:0] inv_a,
  output logic [W-1:0] inv_p,
  input  logic [W-1:0] inv_r,
  input  logic         inv_done,
  output logic         mul_start,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic [W-1:0] mul_p,
  input  logic [W-1:0] mul_r,
  input  logic         mul_done
);

  typedef enum logic [3:0] {
    IDLE, INV_I, INV_W, M1_I, M1_W, M2_I, M2_W, M3_I, M3_W, M4_I, M4_W, DONE
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0] xj_q, yj_q, zj_q, p_q;
  logic [W-1:0] zi_q, z2_q, xr_q, z3i_q;
  logic [W-1:0] x_q, y_q;
  logic         inf_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: the working registers are reset too, so an aborted conversion leaves
  // no stale intermediate behind.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      xj_q  <= '0;
      yj_q  <= '0;
      zj_q  <= '0;
      p_q   <= '0;
      zi_q  <= '0;
      z2_q  <= '0;
      xr_q  <= '0;
      z3i_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      inf_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          xj_q <= x3;
          yj_q <= y3;
          zj_q <= z3;
          p_q  <= p;
          if (z3 == '0) begin
            inf_q <= 1'b1;
            x_q   <= '0;
            y_q   <= '0;
          end
        end
        INV_W: if (inv_done) zi_q  <= inv_r;
        M1_W:  if (mul_done) z2_q  <= mul_r;
        M2_W:  if (mul_done) xr_q  <= mul_r;
        M3_W:  if (mul_done) z3i_q <= mul_r;
        // The result registers move only on the DONE entry edge.
        M4_W: if (mul_done) begin
          x_q   <= xr_q;
          y_q   <= mul_r;
          inf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    inv_start = 1'b0;
    inv_a     = '0;
    inv_p     = '0;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    mul_p     = '0;
    unique case (state_q)
      IDLE:  if (start) state_d = (z3 == '0) ? DONE : INV_I;
      INV_I: begin inv_start = 1'b1; inv_a = zj_q; inv_p = p_q; state_d = INV_W; end
      INV_W: begin inv_a = zj_q; inv_p = p_q; if (inv_done) state_d = M1_I; end
      M1_I:  begin mul_start = 1'b1; mul_a = zi_q; mul_b = zi_q; mul_p = p_q; state_d = M1_W; end
      M1_W:  begin mul_a = zi_q; mul_b = zi_q; mul_p = p_q; if (mul_done) state_d = M2_I; end
      M2_I:  begin mul_start = 1'b1; mul_a = xj_q; mul_b = z2_q; mul_p = p_q; state_d = M2_W; end
      M2_W:  begin mul_a = xj_q; mul_b = z2_q; mul_p = p_q; if (mul_done) state_d = M3_I; end
      M3_I:  begin mul_start = 1'b1; mul_a = z2_q; mul_b = zi_q; mul_p = p_q; state_d = M3_W; end
      M3_W:  begin mul_a = z2_q; mul_b = zi_q; mul_p = p_q; if (mul_done) state_d = M4_I; end
      M4_I:  begin mul_start = 1'b1; mul_a = yj_q; mul_b = z3i_q; mul_p = p_q; state_d = M4_W; end
      M4_W:  begin mul_a = yj_q; mul_b = z3i_q; mul_p = p_q; if (mul_done) state_d = DONE; end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign inf  = inf_q;
  assign x    = x_q;
  assign y    = y_q;

endmodule

// File: tb/tb_jacob_to_affine_ctrl.sv
// Bench for jacob_to_affine_ctrl: 3-cycle stub engines plus a scoreboard of
// expected conversion results and done cycles.
module tb_jacob_to_affine_ctrl;

  localparam int W   = 256;
  localparam int W2  = 2 * W;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start;
  logic [W-1:0] x3, y3, z3, p;
  logic         busy, done, inf;
  logic [W-1:0] x, y;
  logic         inv_start, inv_done, mul_start, mul_done;
  logic [W-1:0] inv_a, inv_p, inv_r;
  logic [W-1:0] mul_a, mul_b, mul_p, mul_r;

  typedef struct {
    logic         inf;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   inv_starts = 0;
  int   mul_starts = 0;
  int   t_start;

  jacob_to_affine_ctrl #(.W(W)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .x3(x3), .y3(y3), .z3(z3), .p(p),
    .busy(busy), .done(done), .inf(inf), .x(x), .y(y),
    .inv_start(inv_start), .inv_a(inv_a), .inv_p(inv_p),
    .inv_r(inv_r), .inv_done(inv_done),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .mul_r(mul_r), .mul_done(mul_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] inv_mod(input logic [W-1:0] a, input logic [W-1:0] m);
    logic [W2-1:0] prod;
    if (m == '0) return '0;
    for (int i = 1; i < 1000; i++) begin
      prod = {{W{1'b0}}, a} * W2'(i);
      if (prod % {{W{1'b0}}, m} == W2'(1)) return W'(i);
    end
    return '0;
  endfunction

  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W2-1:0] prod;
    if (m == '0) return '0;
    prod = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, m};
    return prod[W-1:0];
  endfunction

  // Reference affine result from plain integer arithmetic on small operands.
  function automatic exp_t model(input longint xx, input longint yy, input longint zz,
                                 input longint pp, input int done_cyc);
    exp_t   e;
    longint zi = 0;
    e.cyc = done_cyc;
    if (zz == 0) begin
      e.inf = 1'b1; e.x = '0; e.y = '0;
      return e;
    end
    for (longint i = 1; i < pp; i++) if ((zz * i) % pp == 1) zi = i;
    e.inf = 1'b0;
    e.x   = W'(((xx * zi % pp) * zi) % pp);
    e.y   = W'((((yy * zi % pp) * zi % pp) * zi) % pp);
    return e;
  endfunction

  // Stub engines: done comes LAT cycles after the start cycle.
  logic [W-1:0] inv_a_l, inv_p_l, inv_res;
  logic [W-1:0] mul_a_l, mul_b_l, mul_p_l, mul_res;
  int           inv_cnt = 0, mul_cnt = 0;
  logic         inv_done_stub = 1'b0, mul_done_stub = 1'b0;
  logic         stray_inv = 1'b0, stray_mul = 1'b0;

  assign inv_done = inv_done_stub | stray_inv;
  assign mul_done = mul_done_stub | stray_mul;
  assign inv_r    = stray_inv ? W'('h2b) : inv_res;
  assign mul_r    = stray_mul ? W'('h1c) : mul_res;

  always @(negedge clk) begin
    inv_done_stub = 1'b0;
    if (inv_start) begin
      inv_starts++;
      inv_cnt = LAT; inv_a_l = inv_a; inv_p_l = inv_p;
      inv_res = inv_mod(inv_a, inv_p);
    end else if (inv_cnt > 0) begin
      if (inv_cnt == 1) begin
        inv_done_stub = 1'b1;
        if (busy) begin
          checks++;
          if (inv_a !== inv_a_l || inv_p !== inv_p_l) begin
            errors++;
            $display("FAIL inv_operands_held: a=%0d p=%0d expected a=%0d p=%0d",
                     inv_a, inv_p, inv_a_l, inv_p_l);
          end
        end
      end
      inv_cnt--;
    end
  end

  always @(negedge clk) begin
    mul_done_stub = 1'b0;
    if (mul_start) begin
      mul_starts++;
      mul_cnt = LAT; mul_a_l = mul_a; mul_b_l = mul_b; mul_p_l = mul_p;
      mul_res = mul_mod(mul_a, mul_b, mul_p);
    end else if (mul_cnt > 0) begin
      if (mul_cnt == 1) begin
        mul_done_stub = 1'b1;
        if (busy) begin
          checks++;
          if (mul_a !== mul_a_l || mul_b !== mul_b_l || mul_p !== mul_p_l) begin
            errors++;
            $display("FAIL mul_operands_held: a=%0d b=%0d p=%0d expected a=%0d b=%0d p=%0d",
                     mul_a, mul_b, mul_p, mul_a_l, mul_b_l, mul_p_l);
          end
        end
      end
      mul_cnt--;
    end
  end

  // Scoreboard consumer: each done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        if (inf !== e.inf || x !== e.x || y !== e.y || cyc != e.cyc || busy !== 1'b1) begin
          errors++;
          $display("FAIL result: inf=%0b x=%0d y=%0d cyc=%0d busy=%0b expected inf=%0b x=%0d y=%0d cyc=%0d busy=1",
                   inf, x, y, cyc, busy, e.inf, e.x, e.y, e.cyc);
        end
      end
    end
  end

  task automatic drive_start(input longint xx, input longint yy, input longint zz,
                             input longint pp);
    @(negedge clk);
    x3 = W'(xx); y3 = W'(yy); z3 = W'(zz); p = W'(pp);
    start = 1'b1;
    t_start = cyc;
    sb.push_back(model(xx, yy, zz, pp, cyc + ((zz == 0) ? 1 : 6 + 5 * LAT)));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b1; start = 1'b0;
    x3 = '0; y3 = '0; z3 = '0; p = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, inf, inv_start, mul_start} !== 5'b0 ||
        (|{x, y, inv_a, inv_p, mul_a, mul_b, mul_p}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b data_nonzero=%b expected flags=00000 data_nonzero=0",
               {busy, done, inf, inv_start, mul_start}, |{x, y, inv_a, inv_p, mul_a, mul_b, mul_p});
    end
    nrst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int i0 = inv_starts, m0 = mul_starts;
    drive_start(9, 5, 3, 29);
    checks++;
    if (busy !== 1'b1 || inv_start !== 1'b1 || inv_a !== W'(3) || inv_p !== W'(29)) begin
      errors++;
      $display("FAIL first_issue: busy=%0b inv_start=%0b inv_a=%0d inv_p=%0d expected 1 1 3 29",
               busy, inv_start, inv_a, inv_p);
    end
    wait_drain(60);
    checks++;
    if (inv_starts - i0 != 1 || mul_starts - m0 != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL engine_starts: inv=%0d mul=%0d busy=%0b expected inv=1 mul=4 busy=0",
               inv_starts - i0, mul_starts - m0, busy);
    end
  endtask

  task automatic test_inf();
    int i0 = inv_starts, m0 = mul_starts;
    drive_start(9, 5, 0, 29);
    wait_drain(10);
    checks++;
    if (inv_starts != i0 || mul_starts != m0 || busy !== 1'b0 || inf !== 1'b1) begin
      errors++;
      $display("FAIL inf_no_engines: inv=%0d mul=%0d busy=%0b inf=%0b expected 0 0 0 1",
               inv_starts - i0, mul_starts - m0, busy, inf);
    end
  endtask

  task automatic test_ignore_start();
    drive_start(9, 5, 3, 29);
    wait_cycle(t_start + 10);
    x3 = W'(7); y3 = W'(8); z3 = W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_stray();
    drive_start(9, 5, 3, 29);
    wait_cycle(t_start + 2);
    stray_mul = 1'b1;
    @(negedge clk);
    stray_mul = 1'b0;
    wait_cycle(t_start + 14);
    stray_inv = 1'b1;
    @(negedge clk);
    stray_inv = 1'b0;
    wait_drain(40);
  endtask

  task automatic test_abort();
    int i0, m0;
    drive_start(9, 5, 3, 29);
    wait_cycle(t_start + 14);
    nrst = 1'b1;
    sb.delete();
    @(negedge clk);
    i0 = inv_starts; m0 = mul_starts;
    checks++;
    if ({busy, done, inf, inv_start, mul_start} !== 5'b0 ||
        (|{x, y, inv_a, inv_p, mul_a, mul_b, mul_p}) !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: flags=%b data_nonzero=%b expected flags=00000 data_nonzero=0",
               {busy, done, inf, inv_start, mul_start}, |{x, y, inv_a, inv_p, mul_a, mul_b, mul_p});
    end
    @(negedge clk);
    nrst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (inv_starts != i0 || mul_starts != m0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: inv=%0d mul=%0d busy=%0b expected 0 0 0",
               inv_starts - i0, mul_starts - m0, busy);
    end
    test_basic();
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    drive_start(9, 5, 3, 29);
    k1 = t_start;
    wait_cycle(k1 + 6 + 5 * LAT);
    drive_start(7, 8, 1, 29);
    k2 = t_start;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%0b expected 1", busy);
    end
    while (cyc < k2 + 5 + 5 * LAT) begin
      checks++;
      if (x !== W'(1) || y !== W'(12)) begin
        errors++;
        $display("FAIL b2b_hold: cycle=%0d x=%0d y=%0d expected x=1 y=12", cyc, x, y);
      end
      @(negedge clk);
    end
    wait_drain(30);
    checks++;
    if (x !== W'(7) || y !== W'(8) || inf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: x=%0d y=%0d inf=%0b expected x=7 y=8 inf=0", x, y, inf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inf();
    test_basic();
    test_ignore_start();
    test_stray();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
